// File: rtl/hex_display_if.sv
// Load/display bus between a requester and hex_display_ctrl.
interface hex_display_if #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VAL_WIDTH  = 32
);
  logic [VAL_WIDTH-1:0]    val;
  logic                    load;
  logic                    mode_dec;
  logic                    blank_lz;
  logic [7*NUM_DIGITS-1:0] segs;
  logic                    busy;
  logic                    done;
  logic                    overflow;

  modport master (
    output val, load, mode_dec, blank_lz,
    input  segs, busy, done, overflow
  );

  modport slave (
    input  val, load, mode_dec, blank_lz,
    output segs, busy, done, overflow
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment driver: hex pass-through or serial double-dabble decimal
// conversion, with leading-zero blanking and an all-dash overflow indication.
module hex_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VAL_WIDTH  = 32
) (
  input  logic         clk,
  input  logic         rst,
  hex_display_if.slave bus
);

  localparam int unsigned DIG_W  = 4 * NUM_DIGITS;
  localparam int unsigned SEG_W  = 7 * NUM_DIGITS;
  localparam int unsigned CNT_W  = $clog2(VAL_WIDTH);
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_LATCH} state_t;

  state_t               state_q;
  logic [VAL_WIDTH-1:0] shreg_q;
  logic [DIG_W-1:0]     bcd_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 conv_ovf_q;
  logic                 mode_q;
  logic                 blank_q;
  logic [SEG_W-1:0]     segs_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;

  logic [DIG_W-1:0]     bcd_adj_c;
  logic [DIG_W-1:0]     bcd_shift_c;
  logic                 bcd_carry_c;
  logic [DIG_W-1:0]     hex_digits_c;
  logic                 hex_ovf_c;
  logic [DIG_W-1:0]     disp_digits_c;
  logic                 disp_ovf_c;
  logic [SEG_W-1:0]     disp_segs_c;
  logic                 leading_c;
  logic [3:0]           nib_c;

  // Active-low a..g pattern for one nibble.
  function automatic logic [6:0] seven_segment(input logic [3:0] d);
    case (d)
      4'h0:    return 7'b1000000;
      4'h1:    return 7'b1111001;
      4'h2:    return 7'b0100100;
      4'h3:    return 7'b0110000;
      4'h4:    return 7'b0011001;
      4'h5:    return 7'b0010010;
      4'h6:    return 7'b0000010;
      4'h7:    return 7'b1111000;
      4'h8:    return 7'b0000000;
      4'h9:    return 7'b0010000;
      4'hA:    return 7'b0001000;
      4'hB:    return 7'b0000011;
      4'hC:    return 7'b1000110;
      4'hD:    return 7'b0100001;
      4'hE:    return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // One double-dabble step: add-3 correction then shift in the next value bit.
  always_comb begin
    bcd_adj_c = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      bcd_adj_c[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                      : bcd_q[4*i +: 4];
    end
  end

  assign bcd_shift_c  = {bcd_adj_c[DIG_W-2:0], shreg_q[VAL_WIDTH-1]};
  assign bcd_carry_c  = bcd_adj_c[DIG_W-1];
  assign hex_digits_c = DIG_W'(shreg_q);

  if (VAL_WIDTH > DIG_W) begin : g_hex_ovf
    assign hex_ovf_c = |shreg_q[VAL_WIDTH-1:DIG_W];
  end else begin : g_no_hex_ovf
    assign hex_ovf_c = 1'b0;
  end

  // Segment image presented at LATCH; scans from the top digit to track leading zeros.
  always_comb begin
    disp_digits_c = mode_q ? bcd_q : hex_digits_c;
    disp_ovf_c    = mode_q ? conv_ovf_q : hex_ovf_c;
    disp_segs_c   = '1;
    leading_c     = 1'b1;
    nib_c         = '0;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      nib_c = disp_digits_c[4*k +: 4];
      if (nib_c != 4'd0) leading_c = 1'b0;
      if (disp_ovf_c)                         disp_segs_c[7*k +: 7] = SEG_DASH;
      else if (blank_q && leading_c && k != 0) disp_segs_c[7*k +: 7] = SEG_BLANK;
      else                                    disp_segs_c[7*k +: 7] = seven_segment(nib_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      conv_ovf_q <= 1'b0;
      mode_q     <= 1'b0;
      blank_q    <= 1'b0;
      segs_q     <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.load) begin
            shreg_q <= bus.val;
            mode_q  <= bus.mode_dec;
            blank_q <= bus.blank_lz;
            if (bus.mode_dec) begin
              bcd_q      <= '0;
              conv_ovf_q <= 1'b0;
              cnt_q      <= CNT_W'(VAL_WIDTH - 1);
              busy_q     <= 1'b1;
              state_q    <= S_CONV;
            end else begin
              state_q <= S_LATCH;
            end
          end
        end
        S_CONV: begin
          bcd_q      <= bcd_shift_c;
          shreg_q    <= {shreg_q[VAL_WIDTH-2:0], 1'b0};
          conv_ovf_q <= conv_ovf_q | bcd_carry_c;
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= S_LATCH;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_LATCH: begin
          segs_q  <= disp_segs_c;
          ovf_q   <= disp_ovf_c;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.segs     = segs_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Randomised bench for hex_display_ctrl against a digit-arithmetic reference model,
// with a 6-digit/32-bit instance and a 1-digit/8-bit instance.
module tb_hex_display_ctrl;

  localparam int unsigned ND_A = 6;
  localparam int unsigned VW_A = 32;
  localparam int unsigned ND_B = 1;
  localparam int unsigned VW_B = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hex_display_if #(.NUM_DIGITS(ND_A), .VAL_WIDTH(VW_A)) a_if ();
  hex_display_if #(.NUM_DIGITS(ND_B), .VAL_WIDTH(VW_B)) b_if ();

  hex_display_ctrl #(.NUM_DIGITS(ND_A), .VAL_WIDTH(VW_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  hex_display_ctrl #(.NUM_DIGITS(ND_B), .VAL_WIDTH(VW_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Standard gfedcba (active-high) glyphs, inverted for the active-low outputs.
  function automatic logic [6:0] glyph(input int d);
    logic [6:0] on;
    case (d)
      0: on = 7'h3F;  1: on = 7'h06;  2: on = 7'h5B;  3: on = 7'h4F;
      4: on = 7'h66;  5: on = 7'h6D;  6: on = 7'h7D;  7: on = 7'h07;
      8: on = 7'h7F;  9: on = 7'h6F; 10: on = 7'h77; 11: on = 7'h7C;
     12: on = 7'h39; 13: on = 7'h5E; 14: on = 7'h79; default: on = 7'h71;
    endcase
    return ~on;
  endfunction

  // Returns {overflow, segs}; digits come from plain division by the display base.
  function automatic logic [56:0] model(input longint unsigned v, input bit dec,
                                        input bit blank, input int nd);
    longint unsigned base, lim, t;
    int dig [8];
    int msd;
    bit ovf;
    logic [55:0] s;
    base = dec ? 64'd10 : 64'd16;
    lim  = 1;
    for (int i = 0; i < nd; i++) lim = lim * base;
    ovf = (v >= lim);
    t   = v;
    msd = 0;
    for (int k = 0; k < nd; k++) begin
      dig[k] = int'(t % base);
      t      = t / base;
      if (dig[k] != 0) msd = k;
    end
    s = '1;
    for (int k = 0; k < nd; k++) begin
      if (ovf)                  s[7*k +: 7] = 7'b0111111;
      else if (blank && k > msd) s[7*k +: 7] = 7'b1111111;
      else                      s[7*k +: 7] = glyph(dig[k]);
    end
    return {ovf, s};
  endfunction

  // Issues one load on dut_a (caller sits at a negedge) and checks the full transaction.
  // intr_at > 0 injects a hex load of 0x777 that many cycles later, which must be ignored.
  task automatic run_a(input logic [31:0] v, input bit dec, input bit blank,
                       input int intr_at, input string tag);
    logic [56:0] m;
    logic [41:0] seg0;
    logic        ovf0;
    int lat, busy_n, done_n;
    bit hold;
    m    = model(longint'(v), dec, blank, int'(ND_A));
    seg0 = a_if.segs;
    ovf0 = a_if.overflow;
    a_if.val = v; a_if.mode_dec = dec; a_if.blank_lz = blank; a_if.load = 1'b1;
    lat = 0; busy_n = 0; done_n = 0; hold = 1'b1;
    while (done_n == 0 && lat < 100) begin
      @(negedge clk);
      lat++;
      a_if.load = 1'b0;
      if (lat == intr_at) begin
        a_if.val = 32'h777; a_if.mode_dec = 1'b0; a_if.load = 1'b1;
      end
      if (a_if.busy) busy_n++;
      if (a_if.done) done_n++;
      else if (a_if.segs !== seg0 || a_if.overflow !== ovf0) hold = 1'b0;
    end
    check({tag, ".latency"}, 64'(lat), dec ? 64'(VW_A + 2) : 64'd2);
    check({tag, ".busy_cycles"}, 64'(busy_n), dec ? 64'(VW_A) : 64'd0);
    check({tag, ".segs"}, 64'(a_if.segs), 64'(m[7*ND_A-1:0]));
    check({tag, ".overflow"}, 64'(a_if.overflow), 64'(m[56]));
    check({tag, ".held"}, 64'(hold), 64'd1);
    if (intr_at > 0) begin
      repeat (VW_A + 4) begin
        @(negedge clk);
        a_if.load = 1'b0;
        if (a_if.done) done_n++;
      end
      check({tag, ".one_done"}, 64'(done_n), 64'd1);
      check({tag, ".kept"}, 64'(a_if.segs), 64'(m[7*ND_A-1:0]));
    end
  endtask

  task automatic run_b(input logic [7:0] v, input bit dec, input string tag);
    logic [56:0] m;
    int lat;
    m = model(longint'(v), dec, 1'b0, int'(ND_B));
    b_if.val = v; b_if.mode_dec = dec; b_if.blank_lz = 1'b0; b_if.load = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      b_if.load = 1'b0;
    end while (!b_if.done && lat < 50);
    check({tag, ".latency"}, 64'(lat), dec ? 64'(VW_B + 2) : 64'd2);
    check({tag, ".segs"}, 64'(b_if.segs), 64'(m[7*ND_B-1:0]));
    check({tag, ".overflow"}, 64'(b_if.overflow), 64'(m[56]));
  endtask

  initial begin
    int done_n;
    logic [31:0] rv;
    rst = 1'b1;
    a_if.val = '0; a_if.load = 1'b0; a_if.mode_dec = 1'b0; a_if.blank_lz = 1'b0;
    b_if.val = '0; b_if.load = 1'b0; b_if.mode_dec = 1'b0; b_if.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.segs", 64'(a_if.segs), 64'(42'h3FF_FFFF_FFFF));
    check("reset.busy", 64'(a_if.busy), 64'd0);
    check("reset.done", 64'(a_if.done), 64'd0);
    check("reset.overflow", 64'(a_if.overflow), 64'd0);
    rst = 1'b0;

    // Directed cases; the first load lands on the first edge after reset release.
    run_a(32'h00AB_CDEF, 1'b0, 1'b0, 0, "hex_abcdef");
    run_a(32'h0100_0000, 1'b0, 1'b0, 0, "hex_ovf");
    run_a(32'd999999,    1'b1, 1'b0, 0, "dec_999999");
    run_a(32'd1000000,   1'b1, 1'b0, 0, "dec_ovf");
    run_a(32'd42,        1'b1, 1'b1, 0, "dec_42_blank");
    run_a(32'd0,         1'b1, 1'b1, 0, "dec_0_blank");
    run_a(32'd42,        1'b1, 1'b0, 0, "dec_42_noblank");
    run_a(32'h0000_00C4, 1'b0, 1'b1, 0, "hex_c4_blank");
    run_a(32'd123,       1'b1, 1'b0, 5, "dec_busy_intr");
    run_a(32'h0000_0A05, 1'b0, 1'b0, 1, "hex_latch_intr");

    // Reset in the middle of a decimal conversion.
    a_if.val = 32'd123456; a_if.mode_dec = 1'b1; a_if.blank_lz = 1'b0; a_if.load = 1'b1;
    @(negedge clk);
    a_if.load = 1'b0;
    repeat (9) @(negedge clk);
    check("midrst.busy_before", 64'(a_if.busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst.busy", 64'(a_if.busy), 64'd0);
    check("midrst.segs", 64'(a_if.segs), 64'(42'h3FF_FFFF_FFFF));
    check("midrst.overflow", 64'(a_if.overflow), 64'd0);
    done_n = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_if.done) done_n++;
    end
    check("midrst.no_done", 64'(done_n), 64'd0);
    rst = 1'b0;
    run_a(32'h5, 1'b0, 1'b1, 0, "midrst.recover");

    // Random traffic, biased toward short values so both fit and overflow occur.
    for (int i = 0; i < 40; i++) begin
      rv = $urandom >> $urandom_range(0, 31);
      run_a(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, $sformatf("rand%0d", i));
    end

    // Single-digit, 8-bit instance.
    run_b(8'h0F, 1'b0, "b_hex_f");
    run_b(8'h10, 1'b0, "b_hex_ovf");
    run_b(8'd9,  1'b1, "b_dec_9");
    run_b(8'd10, 1'b1, "b_dec_ovf");
    for (int i = 0; i < 8; i++) begin
      run_b(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $sformatf("b_rand%0d", i));
    end

    @(negedge clk);
    check("final.done_low", 64'(a_if.done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
